// File: rtl/mux_ctrl_pkg.sv
// Shared types and helpers for the analog mux scan controller.
package mux_ctrl_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BREAK   = 2'd1,
        CONNECT = 2'd2
    } state_t;

    // Channel index to NMOS gate pattern.
    function automatic logic [NUM_CH-1:0] onehot4(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic-width two-flop synchroniser for asynchronous pin inputs.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back flops; first stage may go metastable, second settles it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Break-before-make gate driver for the 4:1 transmission-gate mux, with
// manual pin select and an auto-scan mode with programmable dwell.
module mux_scan_ctrl
    import mux_ctrl_pkg::*;
#(
    parameter int DEAD_CYCLES = 2,
    parameter int DWELL_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [1:0]         sel_in,
    input  logic               auto_en,
    input  logic [DWELL_W-1:0] dwell_cfg,
    output logic [3:0]         n_sel,
    output logic [3:0]         p_sel,
    output logic [1:0]         ch_idx,
    output logic               ch_valid
);

    // Dead counter counts DEAD_CYCLES-1 down to 0, so it only needs to hold DEAD_CYCLES-1.
    localparam int DEAD_W = (DEAD_CYCLES > 2) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

    generate
        if (DEAD_CYCLES < 1) begin : g_bad_dead
            $error("mux_scan_ctrl: DEAD_CYCLES must be at least 1");
        end
    endgenerate

    logic [CH_W-1:0]    sel_s;
    logic               auto_s;
    state_t             state, state_nxt;
    logic [CH_W-1:0]    ch_idx_q, ch_nxt;
    logic [DEAD_W-1:0]  dead_cnt, dead_nxt;
    logic [DWELL_W-1:0] dwell_cnt, dwell_nxt, dwell_load;
    logic [NUM_CH-1:0]  n_sel_d;
    logic               ch_valid_d;

    sync_2ff #(.W(CH_W)) u_sel_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sel_in),
        .q     (sel_s)
    );

    sync_2ff #(.W(1)) u_auto_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (auto_en),
        .q     (auto_s)
    );

    // A zero dwell would never expire cleanly; treat it as one cycle.
    assign dwell_load = (dwell_cfg == '0) ? DWELL_W'(1) : dwell_cfg;

    // State, target channel and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch_idx_q  <= '0;
            dead_cnt  <= '0;
            dwell_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ch_idx_q  <= ch_nxt;
            dead_cnt  <= dead_nxt;
            dwell_cnt <= dwell_nxt;
        end
    end

    // Next-state decode: ena low wins, every path into CONNECT goes through BREAK.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch_idx_q;
        dead_nxt  = dead_cnt;
        dwell_nxt = dwell_cnt;
        if (!ena) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BREAK;
                    ch_nxt    = auto_s ? '0 : sel_s;
                    dead_nxt  = DEAD_LOAD;
                end
                BREAK: begin
                    // Retarget freely while off; the dead time keeps running.
                    if (!auto_s) begin
                        ch_nxt = sel_s;
                    end
                    if (dead_cnt == '0) begin
                        state_nxt = CONNECT;
                        dwell_nxt = dwell_load;
                    end else begin
                        dead_nxt = dead_cnt - 1'b1;
                    end
                end
                CONNECT: begin
                    if (auto_s) begin
                        if (dwell_cnt <= DWELL_W'(1)) begin
                            state_nxt = BREAK;
                            ch_nxt    = ch_idx_q + 1'b1;
                            dead_nxt  = DEAD_LOAD;
                        end else begin
                            dwell_nxt = dwell_cnt - 1'b1;
                        end
                    end else begin
                        // Hold the reload value so entering auto gives a full dwell.
                        dwell_nxt = dwell_load;
                        if (sel_s != ch_idx_q) begin
                            state_nxt = BREAK;
                            ch_nxt    = sel_s;
                            dead_nxt  = DEAD_LOAD;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode from the next state so the gate registers line up with the state.
    always_comb begin
        n_sel_d    = '0;
        ch_valid_d = 1'b0;
        if (state_nxt == CONNECT) begin
            n_sel_d    = onehot4(ch_nxt);
            ch_valid_d = 1'b1;
        end
    end

    // Registered gate drives; p_sel is its own flop so it never glitches against n_sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_sel    <= '0;
            p_sel    <= '1;
            ch_valid <= 1'b0;
        end else begin
            n_sel    <= n_sel_d;
            p_sel    <= ~n_sel_d;
            ch_valid <= ch_valid_d;
        end
    end

    assign ch_idx = ch_idx_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl.
module tb_mux_scan_ctrl;

    localparam int DEAD    = 2;
    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ena;
    logic [1:0]         sel_in;
    logic               auto_en;
    logic [DWELL_W-1:0] dwell_cfg;
    logic [3:0]         n_sel;
    logic [3:0]         p_sel;
    logic [1:0]         ch_idx;
    logic               ch_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl #(.DEAD_CYCLES(DEAD), .DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .sel_in    (sel_in),
        .auto_en   (auto_en),
        .dwell_cfg (dwell_cfg),
        .n_sel     (n_sel),
        .p_sel     (p_sel),
        .ch_idx    (ch_idx),
        .ch_valid  (ch_valid)
    );

    typedef struct {
        logic       ena;
        logic       auto_m;
        logic [1:0] sel;
        logic [7:0] dwell;
        int         wait_n;
        logic [3:0] exp_n;
        logic [1:0] exp_idx;
        logic       exp_v;
        bit         chk_idx;
    } vec_t;

    vec_t vt[12];

    function automatic logic [3:0] oh(input logic [1:0] i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] en, input logic [1:0] ei,
                             input logic ev, input bit ci);
        logic [3:0] ep;
        ep = ~en;
        check({tag, ".n_sel"}, n_sel, en);
        check({tag, ".p_sel"}, p_sel, ep);
        check({tag, ".ch_valid"}, ch_valid, ev);
        if (ci) check({tag, ".ch_idx"}, ch_idx, ei);
    endtask

    // Auto-scan expectation from the scan rules: after enabling, each slot is
    // DEAD off cycles followed by max(dwell,1) on cycles, channel = slot mod 4.
    task automatic run_auto(input string tag, input int dw, input int n);
        int         dwe, len, pos, slot;
        logic [3:0] en;
        logic [1:0] ch;
        logic       on;
        dwe = (dw == 0) ? 1 : dw;
        len = DEAD + dwe;
        for (int i = 1; i <= n; i++) begin
            tick(1);
            pos  = (i - 1) % len;
            slot = (i - 1) / len;
            on   = (pos >= DEAD);
            ch   = 2'(slot % 4);
            en   = on ? oh(ch) : 4'b0000;
            check_out(tag, en, ch, on, 1'b1);
        end
    endtask

    // Every-cycle invariants plus the minimum dead time between connections.
    int         gap;
    bit         have_prev;
    logic [3:0] last_n;
    logic [3:0] inv_n;
    always @(negedge clk) begin
        if (!rst_n) begin
            have_prev = 1'b0;
            gap       = 0;
        end else begin
            inv_n = ~n_sel;
            check("inv_p_sel", p_sel, inv_n);
            check("onehot_n_sel", ($countones(n_sel) <= 1), 1);
            check("valid_vs_n_sel", ch_valid, (n_sel != 4'b0000));
            if (ch_valid) check("n_sel_vs_idx", n_sel, oh(ch_idx));
            if (n_sel == 4'b0000) begin
                gap++;
            end else begin
                if (have_prev && (gap > 0 || n_sel != last_n))
                    check("dead_gap", (gap >= DEAD), 1);
                last_n    = n_sel;
                gap       = 0;
                have_prev = 1'b1;
            end
        end
    end

    logic [1:0] rs;
    int         rdw;

    initial begin
        //                ena auto sel dwell wait  n_sel    idx  v  chk_idx
        vt[0]  = '{1'b1, 1'b0, 2'd0, 8'd3, 8, 4'b0001, 2'd0, 1'b1, 1'b1};
        vt[1]  = '{1'b1, 1'b0, 2'd3, 8'd3, 8, 4'b1000, 2'd3, 1'b1, 1'b1};
        vt[2]  = '{1'b1, 1'b0, 2'd2, 8'd3, 8, 4'b0100, 2'd2, 1'b1, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 2'd2, 8'd3, 1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 2'd1, 8'd3, 6, 4'b0000, 2'd0, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 2'd1, 8'd3, 1, 4'b0000, 2'd1, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 1'b0, 2'd1, 8'd3, 1, 4'b0000, 2'd1, 1'b0, 1'b1};
        vt[7]  = '{1'b1, 1'b0, 2'd1, 8'd3, 1, 4'b0010, 2'd1, 1'b1, 1'b1};
        // Auto switched on mid-CONNECT: full fresh dwell of 5 before moving on.
        vt[8]  = '{1'b1, 1'b1, 2'd1, 8'd5, 6, 4'b0010, 2'd1, 1'b1, 1'b1};
        vt[9]  = '{1'b1, 1'b1, 2'd1, 8'd5, 1, 4'b0000, 2'd2, 1'b0, 1'b1};
        vt[10] = '{1'b1, 1'b1, 2'd1, 8'd5, 1, 4'b0000, 2'd2, 1'b0, 1'b1};
        vt[11] = '{1'b1, 1'b1, 2'd1, 8'd5, 1, 4'b0100, 2'd2, 1'b1, 1'b1};

        rst_n     = 1'b0;
        ena       = 1'b0;
        sel_in    = 2'd0;
        auto_en   = 1'b0;
        dwell_cfg = 8'd3;

        // Reset state
        tick(3);
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        tick(2);
        check_out("idle", 4'b0000, 2'd0, 1'b0, 1'b1);

        // Manual start on channel 2
        sel_in = 2'd2;
        tick(4);
        ena = 1'b1;
        tick(1); check_out("start_brk0", 4'b0000, 2'd2, 1'b0, 1'b1);
        tick(1); check_out("start_brk1", 4'b0000, 2'd2, 1'b0, 1'b1);
        tick(1); check_out("start_conn", 4'b0100, 2'd2, 1'b1, 1'b1);

        // Manual switch 2 -> 1
        sel_in = 2'd1;
        tick(2); check_out("sw_sync", 4'b0100, 2'd2, 1'b1, 1'b1);
        tick(1); check_out("sw_brk0", 4'b0000, 2'd1, 1'b0, 1'b1);
        tick(1); check_out("sw_brk1", 4'b0000, 2'd1, 1'b0, 1'b1);
        tick(1); check_out("sw_conn", 4'b0010, 2'd1, 1'b1, 1'b1);

        // Table of steady-state and timed vectors
        for (int i = 0; i < 12; i++) begin
            ena       = vt[i].ena;
            auto_en   = vt[i].auto_m;
            sel_in    = vt[i].sel;
            dwell_cfg = vt[i].dwell;
            tick(vt[i].wait_n);
            check_out($sformatf("vec%0d", i), vt[i].exp_n, vt[i].exp_idx, vt[i].exp_v, vt[i].chk_idx);
        end

        // Auto scan, dwell 3: 20-cycle period, wrap 3 -> 0
        ena = 1'b0; auto_en = 1'b1; dwell_cfg = 8'd3;
        tick(3);
        ena = 1'b1;
        run_auto("auto3", 3, 25);

        // Dwell 0 behaves as 1
        ena = 1'b0; dwell_cfg = 8'd0;
        tick(3);
        ena = 1'b1;
        run_auto("auto0", 0, 15);

        // Enable drop mid-CONNECT on channel 3
        ena = 1'b0; auto_en = 1'b0; sel_in = 2'd3;
        tick(3);
        ena = 1'b1;
        tick(6); check_out("drop_conn", 4'b1000, 2'd3, 1'b1, 1'b1);
        ena = 1'b0;
        tick(1); check_out("drop_off", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick(2);
        ena = 1'b1;
        tick(1); check_out("reen_brk0", 4'b0000, 2'd3, 1'b0, 1'b1);
        tick(1); check_out("reen_brk1", 4'b0000, 2'd3, 1'b0, 1'b1);
        tick(1); check_out("reen_conn", 4'b1000, 2'd3, 1'b1, 1'b1);

        // Random manual selects with occasional enable drops
        for (int r = 0; r < 20; r++) begin
            rs     = 2'($urandom_range(0, 3));
            sel_in = rs;
            if ($urandom_range(0, 5) == 0) begin
                ena = 1'b0;
                tick($urandom_range(1, 3));
                check("rnd_off.n_sel", n_sel, 4'b0000);
                ena = 1'b1;
            end
            tick($urandom_range(6, 12));
            check_out("rnd_man", oh(rs), rs, 1'b1, 1'b1);
        end

        // Random auto dwells over two full rotations
        for (int r = 0; r < 3; r++) begin
            rdw       = $urandom_range(0, 6);
            ena       = 1'b0;
            auto_en   = 1'b1;
            dwell_cfg = 8'(rdw);
            tick(3);
            ena = 1'b1;
            run_auto($sformatf("rnd_auto_dw%0d", rdw), rdw,
                     8 * (DEAD + ((rdw == 0) ? 1 : rdw)) + 2);
        end

        // Asynchronous reset while connected on channel 2
        auto_en = 1'b0; sel_in = 2'd2;
        tick(10);
        check_out("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_out("rst_async", 4'b0000, 2'd0, 1'b0, 1'b1);
        ena = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check_out("post_rst", 4'b0000, 2'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Digital control-side driver for the 4:1 analog transmission-gate mux. It generates the complementary gate controls n_sel[3:0] and p_sel[3:0] with guaranteed break-before-make, so two channels are never on together. It supports a manual channel select from pins and an auto-scan mode that steps through the channels with a programmable dwell. It sits between ui_in and the analog mux, replacing the purely combinational select decode.

Parameters:
DEAD_CYCLES, 2, number of all-off clock cycles between any two channel connections; must be at least 1 (elaboration error if 0).
DWELL_W, 8, width of dwell_cfg and of the dwell counter.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  block enable; low forces all switches off
sel_in  input  2  manual channel select, asynchronous pin input
auto_en  input  1  1 = auto-scan mode, 0 = manual mode; asynchronous pin input
dwell_cfg  input  DWELL_W  connected time per channel in auto mode, in cycles
n_sel  output  4  NMOS gate controls, one-hot or all zero, active high
p_sel  output  4  PMOS gate controls, always the bitwise inverse of n_sel, active low
ch_idx  output  2  current or target channel index
ch_valid  output  1  high while a channel is connected (CONNECT state)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: n_sel=0000, p_sel=1111, ch_idx=0, ch_valid=0, state=IDLE, dwell counter=0.
- All outputs are registered and glitch-free. The invariant p_sel == ~n_sel holds in every cycle, and popcount(n_sel) <= 1.
- sel_in and auto_en each pass through a 2-flop synchroniser (2-cycle latency). ena and dwell_cfg are synchronous and used directly.
- States:
  - IDLE: all switches off.
  - BREAK: all switches off; dead counter runs.
  - CONNECT: n_sel = onehot(ch_idx), ch_valid=1.
- IDLE -> BREAK: on the first edge with ena=1. The target is loaded into ch_idx: synced sel_in in manual mode, 0 in auto mode. The dead counter is loaded.
- BREAK -> CONNECT: after exactly DEAD_CYCLES cycles of all-off outputs. The dwell counter loads max(dwell_cfg,1) on CONNECT entry.
- CONNECT, manual mode: if synced sel_in != ch_idx, go to BREAK on the next edge. ch_idx takes the new value; outputs go all-off on that edge.
- CONNECT, auto mode: the dwell counter decrements each cycle. When it expires, go to BREAK with ch_idx = ch_idx+1 mod 4 (3 wraps to 0). The connected time is exactly max(dwell_cfg,1) cycles; dwell_cfg=0 is treated as 1.
- While auto mode is off, the dwell counter holds its reload value. A synced auto_en rising edge during CONNECT gives a full fresh dwell.
- Manual sel change during BREAK: ch_idx updates to the latest synced sel. The dead counter is not restarted, so the all-off time is still DEAD_CYCLES.
- ena=0 has priority over everything: from any state, the next edge goes to IDLE with all off and ch_valid=0. Re-enabling always passes through a full BREAK.
- rst_n assertion mid-CONNECT clears outputs immediately (asynchronously) to the reset values.
- Between any two CONNECT periods there are at least DEAD_CYCLES cycles with n_sel=0000.

Decomposition:
- Package mux_ctrl_pkg:
  - state enum {IDLE, BREAK, CONNECT}
  - NUM_CH=4, CH_W=2
  - onehot4 function (index -> 4-bit one-hot)
- Sub-module sync_2ff: a generic-width two-flop synchroniser, reset to 0, used for sel_in and auto_en.

Test Plan:
- Reset: assert rst_n=0 while in CONNECT on ch 2 -> n_sel=0000, p_sel=1111, ch_valid=0 immediately, without waiting for a clock edge.
- Manual start: auto_en=0, sel_in=2 (held), ena 0->1 -> 2 cycles of all-off, then n_sel=0100, p_sel=1011, ch_idx=2, ch_valid=1.
- Manual switch: from CONNECT ch 2, change sel_in to 1 -> after 2 sync cycles, then exactly 2 all-off cycles, n_sel=0010. The bench checks n_sel is never 0110, and checks p_sel==~n_sel every cycle.
- Auto scan: auto_en=1, dwell_cfg=3, DEAD_CYCLES=2 -> n_sel sequence 0001,0010,0100,1000,0001; each channel on for 3 cycles with 2 off between; the period is 20 cycles and ch_idx wraps from 3 to 0.
- Dwell edge case: dwell_cfg=0 in auto mode -> each channel on for exactly 1 cycle, with 2 off between.
- Enable drop: ena->0 mid-CONNECT on ch 3 -> the next edge gives n_sel=0000 and ch_valid=0. Setting ena back to 1 gives 2 all-off cycles before any connection.
